dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the 5-stage pipeline. It sits at the MEM stage, serving the load/store requests the pipeline issues (EX/MEM address, write data, memread/memwrite). It holds the pipeline with a stall signal until each access completes after a fixed, parameterised latency. It replaces the zero-latency combinational data memory, so the pipeline can be exercised against realistic memory timing.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥ 4.
- LATENCY, 4: cycles from request acceptance to completion; ≥ 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- memread_i  in  1  load request (EX/MEM memread).
- memwrite_i  in  1  store request (EX/MEM memwrite).
- addr_i  in  32  byte address (EX/MEM ALU result).
- data_i  in  32  store data (EX/MEM rt data).
- data_o  out  32  load data; valid when ack_o=1 for a read.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse coincident with ack_o when the access faulted.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - A request exists when memread_i|memwrite_i.
  - On a request, latch addr, data and op, and load cnt=LATENCY-1.
  - Next state is DONE if LATENCY=1, else WAIT.
  - stall_o=1 combinationally in the accepting cycle.
- WAIT:
  - stall_o=1; cnt decrements.
  - When cnt reaches 1, the next state is DONE.
  - Inputs are ignored; the latched copies are used.
- DONE:
  - ack_o=1 and stall_o=0; the pipeline advances on this edge.
  - The access executes using the latched values:
    - write: stores mem[idx] on the DONE edge.
    - read: data_o=mem[idx] during DONE.
  - Next state is IDLE unconditionally. The still-present request in DONE is the same instruction and is never re-accepted.
- Index: idx = addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Faults, both reported in DONE with err_o=1 and ack_o=1:
  - Misaligned (addr[1:0]≠0): no write; data_o=0.
  - Both memread and memwrite high: no access; data_o=0.
- data_o holds its last value outside DONE; it updates only on a completed read or fault.
- Memory array: not reset; contents are undefined until written.

## Timing
- Request first seen in IDLE at cycle t → ack_o at t+LATENCY.
- stall_o is high for cycles t .. t+LATENCY-1 (exactly LATENCY stall cycles).
- Back-to-back requests: the next request is accepted in the IDLE cycle at t+LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- Reset values: state=IDLE, cnt=0, data_o=0, stall_o=0, ack_o=0, err_o=0.
- stall_o is combinational from state and the request inputs (IDLE path). ack_o and err_o are decoded from registered state only.
- Reset asserted mid-access (WAIT or DONE) returns to IDLE immediately. A pending write is dropped; an already-written word is retained.
- Request deasserted while in WAIT: the access still completes (latched).

## Structure
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, DONE}
  - default LATENCY and DEPTH_WORDS constants
  - function computing the index width
- Sub-module dmem_array:
  - synchronous-write, asynchronous-read word array (DEPTH_WORDS×32)
  - ports: clk_i, we, widx, wdata, ridx, rdata
- Top-level contents: FSM, counter, latches and fault decode.

## Test plan
- Store then load, LATENCY=4:
  - Store 0xDEADBEEF to 0x10 at t0: stall_o high t0–t3, ack_o at t4, err_o=0.
  - Load from 0x10 at t5: ack_o at t9 with data_o=0xDEADBEEF.
- LATENCY=1:
  - Store 0x00000005 to 0x0 at t0: one stall cycle, ack at t1.
  - Load from 0x0: data_o=5 one cycle after acceptance.
- Misaligned and conflicting requests:
  - Store to 0x13: err_o=1 with ack; a subsequent load from 0x10 still returns the prior value.
  - memread=memwrite=1: err_o=1, data_o=0.
- Wrap-around, DEPTH_WORDS=256:
  - Store 0x12345678 to 0x400.
  - Load from 0x0 returns 0x12345678.
- Reset mid-operation:
  - Store 0xCAFEF00D to 0x20, then assert rst_i=0 two cycles after acceptance.
  - stall_o and ack_o drop to 0 immediately; state is IDLE.
  - A later load from 0x20 returns the old value (no write occurred).
- Request held through DONE:
  - Keep memread_i high continuously from t0.
  - Exactly one ack at t+LATENCY.
  - Re-acceptance occurs only in the following IDLE cycle, with a second ack at t+2·LATENCY+1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_LATENCY     = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;

    // Word-index width for a power-of-two word count.
    function automatic int unsigned idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, asynchronous read. Contents are not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned IDX_W       = idx_width(DEF_DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with fixed access latency; stalls the pipeline until
// each load/store completes and reports misaligned or conflicting requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o,
    output logic              ack_o,
    output logic              err_o
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              misal_q;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              req;
    logic              fault;
    logic              done;
    logic              we;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] done_data;
    logic              unused_addr;

    assign req   = memread_i | memwrite_i;
    assign done  = (state_q == DONE);
    assign fault = misal_q | (rd_q & wr_q);
    assign we    = done & wr_q & ~fault;

    // Upper address bits are intentionally ignored: addresses wrap.
    assign unused_addr = ^addr_i[ADDR_W-1:IDX_W+2];

    // Request latch, latency counter and state sequencing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            misal_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= addr_i[2 +: IDX_W];
                        misal_q <= (addr_i[1:0] != 2'b00);
                        rd_q    <= memread_i;
                        wr_q    <= memwrite_i;
                        wdata_q <= data_i;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rd_q | fault) begin
                        rdata_q <= done_data;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .we    (we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (idx_q),
        .rdata (arr_rdata)
    );

    // Faulted accesses return zero; a clean read returns the addressed word.
    assign done_data = fault ? '0 : arr_rdata;
    assign data_o    = (done & (rd_q | fault)) ? done_data : rdata_q;

    assign stall_o = ((state_q == IDLE) & req) | (state_q == WAIT);
    assign ack_o   = done;
    assign err_o   = done & fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=4/DEPTH=256 and one at LATENCY=1.
module tb_dmem_responder;

    logic clk;
    int   n_tests;
    int   n_fail;

    logic        a_rst, a_rd, a_wr, a_stall, a_ack, a_err;
    logic [31:0] a_addr, a_wdata, a_data_o;
    logic        b_rst, b_rd, b_wr, b_stall, b_ack, b_err;
    logic [31:0] b_addr, b_wdata, b_data_o;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut_a (
        .clk_i      (clk),
        .rst_i      (a_rst),
        .memread_i  (a_rd),
        .memwrite_i (a_wr),
        .addr_i     (a_addr),
        .data_i     (a_wdata),
        .data_o     (a_data_o),
        .stall_o    (a_stall),
        .ack_o      (a_ack),
        .err_o      (a_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_b (
        .clk_i      (clk),
        .rst_i      (b_rst),
        .memread_i  (b_rd),
        .memwrite_i (b_wr),
        .addr_i     (b_addr),
        .data_i     (b_wdata),
        .data_o     (b_data_o),
        .stall_o    (b_stall),
        .ack_o      (b_ack),
        .err_o      (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on instance A; returns stall count, ack offset and data/err at ack.
    task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls, output int ack_at,
                            output logic [31:0] dout, output logic err);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        stalls = 0; ack_at = -1; dout = 'x; err = 1'bx;
        for (int k = 0; k < 20 && ack_at < 0; k++) begin
            @(negedge clk);
            if (a_stall) stalls++;
            if (a_ack) begin
                ack_at = k; dout = a_data_o; err = a_err;
            end
            @(posedge clk); #1;
        end
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic access_b(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls, output int ack_at,
                            output logic [31:0] dout, output logic err);
        b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
        stalls = 0; ack_at = -1; dout = 'x; err = 1'bx;
        for (int k = 0; k < 20 && ack_at < 0; k++) begin
            @(negedge clk);
            if (b_stall) stalls++;
            if (b_ack) begin
                ack_at = k; dout = b_data_o; err = b_err;
            end
            @(posedge clk); #1;
        end
        b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        #3;
        n_tests++;
        if ({a_stall, a_ack, a_err} !== 3'b000 || a_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_a: stall/ack/err=%b data=%h, want 000 data=0",
                     {a_stall, a_ack, a_err}, a_data_o);
        end
        n_tests++;
        if ({b_stall, b_ack, b_err} !== 3'b000 || b_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_b: stall/ack/err=%b data=%h, want 000 data=0",
                     {b_stall, b_ack, b_err}, b_data_o);
        end
        repeat (2) @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int s, t; logic [31:0] d; logic e;
        access_a(0, 1, 32'h10, 32'hDEADBEEF, s, t, d, e);
        n_tests++;
        if (s !== 4 || t !== 4 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL store_lat4: stalls=%0d ack_at=%0d err=%b, want 4 4 0", s, t, e);
        end
        access_a(1, 0, 32'h10, 32'h0, s, t, d, e);
        n_tests++;
        if (s !== 4 || t !== 4 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_lat4: stalls=%0d ack_at=%0d err=%b data=%h, want 4 4 0 deadbeef",
                     s, t, e, d);
        end
    endtask

    task automatic test_latency1();
        int s, t; logic [31:0] d; logic e;
        access_b(0, 1, 32'h0, 32'h5, s, t, d, e);
        n_tests++;
        if (s !== 1 || t !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL store_lat1: stalls=%0d ack_at=%0d err=%b, want 1 1 0", s, t, e);
        end
        access_b(1, 0, 32'h0, 32'h0, s, t, d, e);
        n_tests++;
        if (s !== 1 || t !== 1 || d !== 32'h5) begin
            n_fail++;
            $display("FAIL load_lat1: stalls=%0d ack_at=%0d data=%h, want 1 1 00000005", s, t, d);
        end
    endtask

    task automatic test_faults();
        int s, t; logic [31:0] d; logic e;
        access_a(0, 1, 32'h13, 32'hBAD0BAD0, s, t, d, e);
        n_tests++;
        if (t !== 4 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_store: ack_at=%0d err=%b, want 4 1", t, e);
        end
        access_a(1, 0, 32'h10, 32'h0, s, t, d, e);
        n_tests++;
        if (e !== 1'b0 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL after_misaligned: err=%b data=%h, want 0 deadbeef", e, d);
        end
        access_a(1, 1, 32'h10, 32'h55555555, s, t, d, e);
        n_tests++;
        if (t !== 4 || e !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL conflict: ack_at=%0d err=%b data=%h, want 4 1 0", t, e, d);
        end
        @(negedge clk);
        n_tests++;
        if (a_data_o !== 32'h0 || a_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_hold: data=%h ack=%b, want 0 0", a_data_o, a_ack);
        end
        @(posedge clk); #1;
        access_a(1, 0, 32'h10, 32'h0, s, t, d, e);
        n_tests++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL after_conflict: data=%h, want deadbeef", d);
        end
        access_a(0, 1, 32'h14, 32'h0BADCAFE, s, t, d, e);
        n_tests++;
        if (e !== 1'b0 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL data_hold_on_store: err=%b data=%h, want 0 deadbeef", e, d);
        end
        access_a(1, 0, 32'h11, 32'h0, s, t, d, e);
        n_tests++;
        if (e !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_load: err=%b data=%h, want 1 0", e, d);
        end
    endtask

    task automatic test_wrap();
        int s, t; logic [31:0] d; logic e;
        access_a(0, 1, 32'h400, 32'h12345678, s, t, d, e);
        access_a(1, 0, 32'h0, 32'h0, s, t, d, e);
        n_tests++;
        if (e !== 1'b0 || d !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wrap: err=%b data=%h, want 0 12345678", e, d);
        end
        access_a(1, 0, 32'h14, 32'h0, s, t, d, e);
        n_tests++;
        if (d !== 32'h0BADCAFE) begin
            n_fail++;
            $display("FAIL wrap_neighbour: data=%h, want 0badcafe", d);
        end
    endtask

    task automatic test_reset_mid();
        int s, t; logic [31:0] d; logic e;
        access_a(0, 1, 32'h20, 32'h11112222, s, t, d, e);
        a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (a_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: stall=%b, want 1", a_stall);
        end
        a_wr = 1'b0;
        a_rst = 1'b0;
        #1;
        n_tests++;
        if (a_stall !== 1'b0 || a_ack !== 1'b0 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: stall=%b ack=%b err=%b, want 0 0 0", a_stall, a_ack, a_err);
        end
        @(negedge clk);
        a_rst = 1'b1;
        @(posedge clk); #1;
        access_a(1, 0, 32'h20, 32'h0, s, t, d, e);
        n_tests++;
        if (s !== 4 || t !== 4 || d !== 32'h11112222) begin
            n_fail++;
            $display("FAIL reset_mid_load: stalls=%0d ack_at=%0d data=%h, want 4 4 11112222",
                     s, t, d);
        end
    endtask

    task automatic test_back_to_back();
        int n_ack, first, second;
        n_ack = 0; first = -1; second = -1;
        a_rd = 1'b1; a_addr = 32'h10;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (a_ack) begin
                n_ack++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            @(posedge clk); #1;
        end
        a_rd = 1'b0;
        n_tests++;
        if (n_ack !== 2 || first !== 4 || second !== 9) begin
            n_fail++;
            $display("FAIL held_request: acks=%0d first=%0d second=%0d, want 2 4 9",
                     n_ack, first, second);
        end
        @(negedge clk);
        n_tests++;
        if (a_stall !== 1'b0 || a_ack !== 1'b0 || a_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL held_release: stall=%b ack=%b data=%h, want 0 0 deadbeef",
                     a_stall, a_ack, a_data_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_store_load();
        test_latency1();
        test_faults();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
